// File: rtl/mips_cpu_data_ram.sv
// Data memory for the CPU data port: combinational word read, clocked word write,
// post-reset clear sequencer and sticky fault capture. Optional access counters
// are built only when DATA_RAM_STATS_EN is defined.
module mips_cpu_data_ram #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        ready,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_idx, clr_idx_next;
  logic [31:0]   mem [DEPTH];

  logic          hit, aligned, run_en, wr_accept, rd_accept, fault_now;
  logic [AW-1:0] idx;

  // BASE_ADDR is aligned to the array size, so a tag compare is the range check
  assign hit       = (data_address[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx       = data_address[AW+1:2];
  assign aligned   = (data_address[1:0] == 2'b00);
  assign run_en    = (state == RUN) && clk_enable;
  assign wr_accept = run_en && data_write && !data_read && hit && aligned;
  assign rd_accept = run_en && data_read && hit;
  assign fault_now = run_en && ((data_read && data_write) ||
                                ((data_read || data_write) && !hit) ||
                                (data_write && !aligned));

  assign ready = (state == RUN);

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (state == CLEAR) begin
      clr_idx_next = clr_idx + 1'b1;
      if (clr_idx == AW'(DEPTH - 1)) state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      if (fault_now && !fault) begin
        fault      <= 1'b1;
        fault_addr <= data_address;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_idx] <= '0;
    else if (wr_accept) mem[idx] <= data_writedata;
  end

  always_comb begin
    data_readdata = '0;
    if ((state == RUN) && data_read && hit) data_readdata = mem[idx];
  end

`ifdef DATA_RAM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_accept) rd_count <= rd_count + 32'd1;
      if (wr_accept) wr_count <= wr_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
  logic unused_stats;
  assign unused_stats = rd_accept;
`endif

endmodule

// File: tb/tb_mips_cpu_data_ram.sv
// Self-checking bench for mips_cpu_data_ram: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_mips_cpu_data_ram;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        ready;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  mips_cpu_data_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .ready(ready), .fault(fault), .fault_addr(fault_addr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_clr;
  bit          m_fault;
  logic [31:0] m_faddr;
  logic [31:0] m_rd, m_wr;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read();
    if (!m_ready || !data_read || !m_hit(data_address)) return 32'h0;
    return m_mem[m_index(data_address)];
  endfunction

  function automatic logic [31:0] exp_rd();
`ifdef DATA_RAM_STATS_EN
    return m_rd;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_wr();
`ifdef DATA_RAM_STATS_EN
    return m_wr;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_ready = 0; m_clr = 0; m_fault = 0; m_faddr = '0; m_rd = '0; m_wr = '0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
  endtask

  task automatic drive(input logic en, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    clk_enable = en; data_read = r; data_write = w;
    data_address = a; data_writedata = wd;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge
  task automatic tick();
    bit h, bad;
    if (reset) begin
      if (!m_ready) begin
        m_clr++;
        if (m_clr == int'(DEPTH)) m_ready = 1;
      end else if (clk_enable) begin
        h   = m_hit(data_address);
        bad = (data_read && data_write) || ((data_read || data_write) && !h) ||
              (data_write && data_address[1:0] != 2'b00);
        if (bad && !m_fault) begin m_fault = 1; m_faddr = data_address; end
        if (data_write && !data_read && h && data_address[1:0] == 2'b00) begin
          m_mem[m_index(data_address)] = data_writedata;
          m_wr++;
        end
        if (data_read && h) m_rd++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    drive(1'b0, 1'b1, 1'b0, BASE, '0);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    n_checks++; if (fault_addr !== 32'h0) begin n_fail++; $display("FAIL reset_fault_addr: got %h expected 0", fault_addr); end
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", data_readdata); end
    n_checks++; if (rd_count !== 32'h0) begin n_fail++; $display("FAIL reset_rd_count: got %h expected 0", rd_count); end
    n_checks++; if (wr_count !== 32'h0) begin n_fail++; $display("FAIL reset_wr_count: got %h expected 0", wr_count); end
  endtask

  // Release reset and walk the clear, checking ready cycle by cycle
  task automatic run_clear(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, BASE, '0);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      tick();
      n_checks++;
      if (ready !== (i == int'(DEPTH)) || ready !== m_ready) begin
        n_fail++; $display("FAIL %s_ready cycle %0d: got %b expected %b", tag, i, ready, i == int'(DEPTH));
      end
    end
  endtask

  task automatic test_clear_timing();
    run_clear("clear");
    drive(1'b0, 1'b1, 1'b0, BASE, '0);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL clear_read_1000: got %h expected 0", data_readdata); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL clear_fault: got %b expected 0", fault); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 1'b1, 32'h1008, 32'hDEADBEEF);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL wr_same_cycle: got %h expected 0", data_readdata); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h1008, '0);
    n_checks++; if (data_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_1008: got %h expected deadbeef", data_readdata); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h100B, '0);
    n_checks++; if (data_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_100b: got %h expected deadbeef", data_readdata); end
    tick();
    n_checks++; if (wr_count !== exp_wr()) begin n_fail++; $display("FAIL wr_count: got %h expected %h", wr_count, exp_wr()); end
    n_checks++; if (rd_count !== exp_rd()) begin n_fail++; $display("FAIL rd_count: got %h expected %h", rd_count, exp_rd()); end
  endtask

  task automatic test_gated_write();
    drive(1'b0, 1'b0, 1'b1, 32'h1004, 32'h12345678);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h1004, '0);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL gated_rd_1004: got %h expected 0", data_readdata); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL gated_fault: got %b expected 0", fault); end
    tick();
  endtask

  task automatic test_faults();
    drive(1'b1, 1'b0, 1'b1, 32'h1002, 32'h1);
    tick();
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault: got %b expected 1", fault); end
    n_checks++; if (fault_addr !== 32'h1002) begin n_fail++; $display("FAIL misalign_addr: got %h expected 1002", fault_addr); end
    drive(1'b1, 1'b1, 1'b0, 32'h1000, '0);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL misalign_word: got %h expected 0", data_readdata); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0FFC, '0);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL miss_read: got %h expected 0", data_readdata); end
    tick();
    n_checks++; if (fault_addr !== 32'h1002) begin n_fail++; $display("FAIL fault_addr_sticky: got %h expected 1002", fault_addr); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1, 1'b1, 32'h100C, 32'hA5A5A5A5);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL simul_read: got %h expected 0", data_readdata); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h100C, '0);
    n_checks++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL simul_suppressed: got %h expected 0", data_readdata); end
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL simul_fault: got %b expected 1", fault); end
    tick();
  endtask

  task automatic test_reset_mid();
    assert_reset();
    run_clear("restart0");
    assert_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, BASE, '0);
    for (int i = 0; i < 5; i++) tick();
    assert_reset();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midclear_ready: got %b expected 0", ready); end
    run_clear("restart1");
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b1, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom | 32'h1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h4, '0);
    tick();
    assert_reset();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrun_ready: got %b expected 0", ready); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL midrun_fault: got %b expected 0", fault); end
    n_checks++; if (rd_count !== 32'h0) begin n_fail++; $display("FAIL midrun_rd_count: got %h expected 0", rd_count); end
    n_checks++; if (wr_count !== 32'h0) begin n_fail++; $display("FAIL midrun_wr_count: got %h expected 0", wr_count); end
    run_clear("restart2");
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b0, 1'b1, 1'b0, BASE + 32'(4 * i), '0);
      n_checks++;
      if (data_readdata !== 32'h0) begin
        n_fail++; $display("FAIL cleared_word %0d: got %h expected 0", i, data_readdata);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, exp;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 75)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel < 85) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (sel < 93) a = BASE - 32'($urandom_range(1, 16));
      else               a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 16));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, a, $urandom);
      exp = m_read();
      n_checks++;
      if (data_readdata !== exp) begin
        n_fail++; $display("FAIL rand_read %0d addr %h: got %h expected %h", n, a, data_readdata, exp);
      end
      tick();
      n_checks++;
      if (fault !== m_fault || fault_addr !== m_faddr) begin
        n_fail++; $display("FAIL rand_fault %0d: got %b/%h expected %b/%h", n, fault, fault_addr, m_fault, m_faddr);
      end
      n_checks++;
      if (rd_count !== exp_rd() || wr_count !== exp_wr()) begin
        n_fail++; $display("FAIL rand_counts %0d: got %h/%h expected %h/%h", n, rd_count, wr_count, exp_rd(), exp_wr());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clk_enable = 1'b0; data_read = 1'b0; data_write = 1'b0;
    data_address = '0; data_writedata = '0;
    model_reset();
    test_reset();
    test_clear_timing();
    test_write_read();
    test_gated_write();
    test_faults();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
